// File: rtl/voting_pkg.sv
// Shared voting definitions: phase codes, default booth/candidate sizing, vote width.
// No logic and no latency; consumed by the booth arbiter and the vote-counter datapath.
// No flow control here; the helper saturates rather than wrapping.
package voting_pkg;

   localparam int N_BOOTH_DEF = 4;
   localparam int CW_DEF      = 2;
   localparam int VOTE_W      = 8;

   localparam logic [VOTE_W-1:0] VOTE_MAX = '1;

   // Election phase; the numeric codes are visible on the phase output.
   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_CLEAR   = 3'd1,
      PH_OPEN    = 3'd2,
      PH_CLOSING = 3'd3,
      PH_CLOSED  = 3'd4
   } phase_e;

   // Ballot tally increment that sticks at the maximum instead of wrapping.
   function automatic logic [VOTE_W-1:0] vote_sat_inc(input logic [VOTE_W-1:0] v);
      return (v == VOTE_MAX) ? v : v + VOTE_W'(1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible booth at or after the pointer, wrapping.
// Purely combinational, zero latency.
// No backpressure; grant_vld_o is low when nothing is eligible.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  eligible_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] grant_idx_o,
   output logic          grant_vld_o
);

   logic [IW-1:0] cand_idx;

   // Walk the booths starting at the pointer and keep the first eligible one.
   always_comb begin
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      cand_idx    = '0;
      for (int k = 0; k < N; k++) begin
         cand_idx = IW'((int'(ptr_i) + k) % N);
         if (!grant_vld_o && eligible_i[cand_idx]) begin
            grant_vld_o = 1'b1;
            grant_idx_o = cand_idx;
         end
      end
   end

endmodule

// File: rtl/booth_arbiter.sv
// Election controller: phase FSM plus round-robin ballot arbitration into shared vote counters.
// Latency: grant registered on the edge sampling the request, ack/cnt_inc one cycle after that.
// Backpressure: booths hold req until ack; requests wait indefinitely outside the OPEN phase.
module booth_arbiter
   import voting_pkg::*;
#(
   parameter int N_BOOTH = N_BOOTH_DEF,
   parameter int CW      = CW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  open_poll,
   input  logic                  close_poll,
   input  logic [N_BOOTH-1:0]    booth_req,
   input  logic [N_BOOTH*CW-1:0] booth_choice,
   output logic [N_BOOTH-1:0]    booth_ack,
   output logic                  cnt_clr,
   output logic                  cnt_inc,
   output logic [CW-1:0]         cnt_sel,
   output logic [2:0]            phase,
   output logic [VOTE_W-1:0]     votes_accepted
);

   localparam int IW = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1;

   phase_e              phase_q, phase_d;
   logic                grant_en;

   logic [N_BOOTH-1:0]  served_q, served_d;
   logic [IW-1:0]       ptr_q, ptr_d;

   // Grant stage: booth picked this cycle, acknowledged next cycle.
   logic                pend_vld_q, pend_vld_d;
   logic [IW-1:0]       pend_idx_q, pend_idx_d;
   logic [CW-1:0]       pend_sel_q, pend_sel_d;

   // Output stage driving the booths and the counter datapath.
   logic [N_BOOTH-1:0]  ack_q, ack_d;
   logic                inc_q, inc_d;
   logic [CW-1:0]       sel_q, sel_d;
   logic [VOTE_W-1:0]   votes_q, votes_d;

   logic [N_BOOTH-1:0]  pend_mask;
   logic [N_BOOTH-1:0]  eligible;
   logic [IW-1:0]       rr_idx;
   logic                rr_vld;
   logic                take;

   rr_arbiter #(
      .N  (N_BOOTH),
      .IW (IW)
   ) u_rr (
      .eligible_i  (eligible),
      .ptr_i       (ptr_q),
      .grant_idx_o (rr_idx),
      .grant_vld_o (rr_vld)
   );

   // Phase next-state: open wins in IDLE/CLOSED, close wins in OPEN, grants only in OPEN.
   always_comb begin
      phase_d  = phase_q;
      grant_en = 1'b0;
      case (phase_q)
         PH_IDLE, PH_CLOSED: begin
            if (open_poll) phase_d = PH_CLEAR;
         end
         PH_CLEAR: begin
            phase_d = PH_OPEN;
         end
         PH_OPEN: begin
            if (close_poll) phase_d = PH_CLOSING;
            else            grant_en = 1'b1;
         end
         PH_CLOSING: begin
            phase_d = PH_CLOSED;
         end
         default: begin
            phase_d = PH_IDLE;
         end
      endcase
   end

   // Eligibility excludes booths already served, with a grant in flight, or being acked now,
   // so a booth that keeps req high across its ack cycle is never counted twice.
   always_comb begin
      pend_mask = '0;
      if (pend_vld_q) pend_mask[pend_idx_q] = 1'b1;
      eligible = booth_req & ~served_q & ~pend_mask & ~ack_q;
      take     = grant_en & rr_vld;
   end

   // Grant stage: latch the chosen booth and its candidate, advance the round-robin pointer.
   always_comb begin
      pend_vld_d = take;
      pend_idx_d = take ? rr_idx : '0;
      pend_sel_d = '0;
      for (int b = 0; b < N_BOOTH; b++) begin
         if (take && (rr_idx == IW'(b))) pend_sel_d = booth_choice[b*CW +: CW];
      end
      ptr_d = ptr_q;
      if (take) ptr_d = (rr_idx == IW'(N_BOOTH - 1)) ? '0 : rr_idx + IW'(1);
   end

   // Output stage, served flags and the saturating ballot tally.
   always_comb begin
      ack_d = '0;
      if (pend_vld_q) ack_d[pend_idx_q] = 1'b1;
      inc_d = pend_vld_q;
      sel_d = pend_sel_q;

      // A booth stays served from its ack until it is seen with req low.
      served_d = booth_req & (served_q | ack_q);

      votes_d = votes_q;
      if (phase_d == PH_CLEAR) votes_d = '0;
      else if (inc_q)          votes_d = vote_sat_inc(votes_q);
   end

   // Phase register.
   always_ff @(posedge clk) begin
      if (rst) phase_q <= PH_IDLE;
      else     phase_q <= phase_d;
   end

   // Arbitration state: served flags, pointer and the grant stage; reset drops any pending grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         served_q   <= '0;
         ptr_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_idx_q <= '0;
         pend_sel_q <= '0;
      end else begin
         served_q   <= served_d;
         ptr_q      <= ptr_d;
         pend_vld_q <= pend_vld_d;
         pend_idx_q <= pend_idx_d;
         pend_sel_q <= pend_sel_d;
      end
   end

   // Output registers toward booths and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q   <= '0;
         inc_q   <= 1'b0;
         sel_q   <= '0;
         votes_q <= '0;
      end else begin
         ack_q   <= ack_d;
         inc_q   <= inc_d;
         sel_q   <= sel_d;
         votes_q <= votes_d;
      end
   end

   assign booth_ack      = ack_q;
   assign cnt_inc        = inc_q;
   assign cnt_sel        = sel_q;
   assign cnt_clr        = (phase_q == PH_CLEAR);
   assign phase          = phase_q;
   assign votes_accepted = votes_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Scoreboard bench for booth_arbiter: a rule-level election model predicts grants and tallies.
// Stimulus drives on negedge+1; the monitor compares on every negedge.
// Booths react to the model's predicted acks, so stimulus never depends on the DUT.
module tb_booth_arbiter;

   localparam int N  = 4;
   localparam int CW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           open_poll;
   logic           close_poll;
   logic [N-1:0]   booth_req;
   logic [N*CW-1:0] booth_choice;
   logic [N-1:0]   booth_ack;
   logic           cnt_clr;
   logic           cnt_inc;
   logic [CW-1:0]  cnt_sel;
   logic [2:0]     phase;
   logic [7:0]     votes_accepted;

   booth_arbiter #(.N_BOOTH(N), .CW(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .open_poll      (open_poll),
      .close_poll     (close_poll),
      .booth_req      (booth_req),
      .booth_choice   (booth_choice),
      .booth_ack      (booth_ack),
      .cnt_clr        (cnt_clr),
      .cnt_inc        (cnt_inc),
      .cnt_sel        (cnt_sel),
      .phase          (phase),
      .votes_accepted (votes_accepted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int b;
      int ch;
      int due;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state (election rules, not RTL structure).
   int   m_phase = 0;
   int   m_votes = 0;
   int   m_ptr   = 0;
   bit   m_served[N];
   int   m_due[N];
   bit   m_rst_seen = 0;
   bit   chk_en = 0;

   // Booth behaviour and scenario requests.
   bit   want[N];
   int   want_ch[N];
   int   want_h[N];
   bit   got[N];
   int   rem[N];
   int   hold[N];
   bit   rand_on = 0;

   int   ack_cnt[N];
   bit   first_arm = 0;
   int   first_ack = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard when an ack is due and checks phase/tally every cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (chk_en) begin
         chk("phase", phase, m_phase);
         chk("votes", votes_accepted, m_votes);
         chk("cnt_clr", cnt_clr, m_phase == 1);
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("ack_vec", booth_ack, 1 << e.b);
            chk("cnt_inc", cnt_inc, 1);
            chk("cnt_sel", cnt_sel, e.ch);
         end else begin
            chk("ack_none", booth_ack, 0);
            chk("cnt_inc_none", cnt_inc, 0);
         end
         if (m_rst_seen) chk("rst_sel", cnt_sel, 0);
         for (int b = 0; b < N; b++) begin
            if (booth_ack[b] === 1'b1) begin
               ack_cnt[b]++;
               if (first_arm && first_ack < 0) first_ack = b;
            end
         end
      end
   end

   // Model of the effect of the coming rising edge given the inputs now applied.
   task automatic model_edge();
      int n;
      int g;
      int c;
      bit elig[N];
      bit ack_now;
      n = cyc;
      m_rst_seen = rst;
      if (rst) begin
         m_phase = 0;
         m_votes = 0;
         m_ptr   = 0;
         for (int b = 0; b < N; b++) begin
            m_served[b] = 0;
            m_due[b]    = -1;
         end
         sb_q.delete();
         return;
      end
      ack_now = 0;
      for (int b = 0; b < N; b++) begin
         elig[b] = booth_req[b] && !m_served[b] && !(m_due[b] >= n);
         if (m_due[b] == n) ack_now = 1;
      end
      for (int b = 0; b < N; b++)
         m_served[b] = booth_req[b] && (m_served[b] || m_due[b] == n);
      if (ack_now && m_votes < 255) m_votes++;
      case (m_phase)
         0, 4: if (open_poll) begin m_phase = 1; m_votes = 0; end
         1:    m_phase = 2;
         2: begin
            if (close_poll) m_phase = 3;
            else begin
               g = -1;
               for (int k = 0; k < N; k++) begin
                  c = (m_ptr + k) % N;
                  if (g < 0 && elig[c]) g = c;
               end
               if (g >= 0) begin
                  sb_q.push_back('{g, int'(booth_choice[g*CW +: CW]), n + 2});
                  m_due[g] = n + 2;
                  m_ptr    = (g + 1) % N;
               end
            end
         end
         3:       m_phase = 4;
         default: m_phase = 0;
      endcase
   endtask

   // Booths drop req after their predicted ack plus an optional hold time.
   task automatic booth_update();
      for (int b = 0; b < N; b++) begin
         if (booth_req[b]) begin
            if (m_due[b] == cyc) begin
               got[b] = 1;
               rem[b] = hold[b];
            end
            if (got[b]) begin
               if (rem[b] == 0) begin
                  booth_req[b] = 1'b0;
                  got[b]       = 0;
               end else begin
                  rem[b]--;
               end
            end
         end
      end
   endtask

   task automatic cycle(input bit op, input bit cp, input bit rs);
      logic [N-1:0] was_low;
      @(negedge clk);
      #1;
      was_low = ~booth_req;
      booth_update();
      for (int b = 0; b < N; b++) begin
         if (was_low[b]) begin
            if (!want[b] && rand_on && $urandom_range(0, 2) == 0) begin
               want[b]    = 1;
               want_ch[b] = $urandom_range(0, 3);
               want_h[b]  = $urandom_range(0, 2);
            end
            if (want[b]) begin
               booth_req[b]               = 1'b1;
               booth_choice[b*CW +: CW]   = CW'(want_ch[b]);
               hold[b]                    = want_h[b];
               got[b]                     = 0;
               want[b]                    = 0;
            end
         end
      end
      open_poll  = op;
      close_poll = cp;
      rst        = rs;
      model_edge();
   endtask

   task automatic ask(input int b, input int ch, input int h);
      want[b]    = 1;
      want_ch[b] = ch;
      want_h[b]  = h;
   endtask

   initial begin
      rst = 1'b1; open_poll = 1'b0; close_poll = 1'b0;
      booth_req = '0; booth_choice = '0;
      for (int b = 0; b < N; b++) begin
         m_served[b] = 0; m_due[b] = -1; want[b] = 0; want_ch[b] = 0; want_h[b] = 0;
         got[b] = 0; rem[b] = 0; hold[b] = 0; ack_cnt[b] = 0;
      end
      model_edge();
      chk_en = 1;

      // Reset then open: IDLE -> CLEAR (one cycle, cnt_clr) -> OPEN with zero tally.
      cycle(0, 0, 1);
      chk("rst_phase", phase, 0);
      chk("rst_ack", booth_ack, 0);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      chk("clear_phase", phase, 1);
      chk("clear_clr", cnt_clr, 1);
      chk("clear_votes", votes_accepted, 0);
      cycle(0, 0, 0);
      chk("open_phase", phase, 2);

      // All four booths at once: acks 0..3 back-to-back.
      for (int b = 0; b < N; b++) ask(b, b, 0);
      repeat (7) cycle(0, 0, 0);
      chk("four_votes", votes_accepted, 4);

      // Booth 2 holds req for five sampled cycles: counted once, again only after re-request.
      for (int b = 0; b < N; b++) ack_cnt[b] = 0;
      ask(2, 3, 3);
      repeat (9) cycle(0, 0, 0);
      chk("hold_once", ack_cnt[2], 1);
      chk("hold_votes", votes_accepted, 5);
      ask(2, 1, 0);
      repeat (4) cycle(0, 0, 0);
      chk("hold_again", ack_cnt[2], 2);

      // Close with a grant in flight: its ack lands in CLOSING; booth 1 waits.
      for (int b = 0; b < N; b++) ack_cnt[b] = 0;
      ask(0, 2, 0);
      cycle(0, 0, 0);
      ask(1, 1, 0);
      cycle(0, 1, 0);
      cycle(0, 0, 0);
      chk("closing_phase", phase, 3);
      chk("closing_ack", booth_ack, 1);
      cycle(0, 0, 0);
      chk("closed_phase", phase, 4);
      repeat (3) cycle(0, 1, 0);
      chk("closed_wait", ack_cnt[1], 0);
      cycle(1, 0, 0);
      repeat (4) cycle(0, 0, 0);
      chk("reopen_ack1", ack_cnt[1], 1);

      // 300 single-booth ballots: tally saturates at 255; reopening clears it.
      for (int i = 0; i < 300; i++) begin
         ask($urandom_range(0, N - 1), $urandom_range(0, 3), 0);
         repeat (3) cycle(0, 0, 0);
      end
      cycle(0, 1, 0);
      repeat (2) cycle(0, 0, 0);
      chk("sat_votes", votes_accepted, 255);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      chk("sat_clear_phase", phase, 1);
      chk("sat_clear_votes", votes_accepted, 0);
      cycle(0, 0, 0);

      // Randomised booths and poll controls with occasional reset.
      rand_on = 1;
      repeat (3000) cycle($urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0,
                          $urandom_range(0, 399) == 0);
      rand_on = 0;

      // Drain outstanding booths in a fresh election.
      cycle(0, 0, 1);
      cycle(1, 0, 0);
      repeat (25) cycle(0, 0, 0);

      // Reset in the cycle after a grant: grant dropped, pointer back to booth 0.
      for (int b = 0; b < N; b++) ack_cnt[b] = 0;
      ask(2, 1, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      chk("rstg_phase", phase, 0);
      chk("rstg_ack", booth_ack, 0);
      chk("rstg_inc", cnt_inc, 0);
      repeat (2) cycle(0, 0, 0);
      chk("rstg_noack", ack_cnt[2], 0);
      ask(0, 0, 0);
      ask(1, 1, 0);
      ask(3, 3, 0);
      first_arm = 1;
      cycle(1, 0, 0);
      repeat (8) cycle(0, 0, 0);
      chk("rstg_first", first_ack, 0);
      repeat (4) cycle(0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter: N_BOOTH, default 4, number of voting booths (requesters).
REQ-002 Parameter: CW, default 2, candidate-index width (2^CW candidates).
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: open_poll  input  1  level; request to start a new election.
REQ-006 Port: close_poll  input  1  level; request to end the election.
REQ-007 Port: booth_req  input  N_BOOTH  per-booth ballot request; held until ack.
REQ-008 Port: booth_choice  input  N_BOOTH*CW  per-booth candidate index; booth b uses bits [b*CW+CW-1 : b*CW]; stable while req high.
REQ-009 Port: booth_ack  output  N_BOOTH  one-cycle pulse; ballot of that booth counted.
REQ-010 Port: cnt_clr  output  1  one-cycle pulse clearing the shared vote counters.
REQ-011 Port: cnt_inc  output  1  one-cycle increment strobe to the shared counters.
REQ-012 Port: cnt_sel  output  CW  candidate to increment; valid only while cnt_inc=1.
REQ-013 Port: phase  output  3  current phase code (see REQ-015).
REQ-014 Port: votes_accepted  output  8  ballots counted this election, saturating.

Function
REQ-015 Phases, encoded: IDLE=0, CLEAR=1, OPEN=2, CLOSING=3, CLOSED=4; no other codes are reachable.
REQ-016 IDLE or CLOSED with open_poll=1 SHALL go to CLEAR; close_poll is ignored in these phases, and open_poll takes priority if both are high.
REQ-017 CLEAR SHALL last exactly one cycle with cnt_clr=1 and votes_accepted cleared to 0, then go to OPEN.
REQ-018 A booth is eligible when booth_req=1 and its served flag=0; served SHALL set on ack and clear on the first cycle booth_req is sampled 0.
REQ-019 In OPEN, each cycle the arbiter SHALL pick one eligible booth round-robin, starting at the booth after the last granted (booth 0 after reset), and register the grant together with that booth's choice.
REQ-020 The cycle after a registered grant: booth_ack[g]=1, cnt_inc=1, cnt_sel=latched choice; latency from req sampled to ack is 1 cycle; sustained throughput is one ballot per cycle.
REQ-021 The granted booth SHALL be excluded from eligibility in the ack cycle, so no ballot is ever counted twice.
REQ-022 votes_accepted SHALL increment on each cnt_inc and hold at 255 (no wrap).
REQ-023 OPEN with close_poll=1 SHALL go to CLOSING; close_poll takes priority over open_poll; no new grant is registered in that cycle.
REQ-024 CLOSING: a grant registered in the previous cycle SHALL complete its ack/cnt_inc; then the block SHALL go to CLOSED; CLOSING lasts exactly one cycle.
REQ-025 In IDLE, CLEAR, CLOSING (new grants) and CLOSED, requests SHALL NOT be granted, acked or counted; they remain pending with no timeout.
REQ-026 booth_ack SHALL be at most one-hot; cnt_inc=1 exactly when booth_ack is non-zero.

Reset
REQ-027 rst=1 SHALL, on the next edge, set phase=IDLE and booth_ack=0, cnt_clr=0, cnt_inc=0, cnt_sel=0, votes_accepted=0. It SHALL also clear all served flags and any pending grant, and set the round-robin pointer to booth 0.
REQ-028 rst SHALL take priority over every other input in any phase; a grant pending at reset SHALL be dropped (no ack, no inc).

Structure
REQ-029 Shared package voting_pkg SHALL hold the phase enum/codes and the N_BOOTH/CW defaults; this package is shared with the counter datapath.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs eligible vector and pointer, outputs grant index and valid); phase FSM, served flags and output registers stay in booth_arbiter.

Verification
REQ-031 Reset, open_poll pulse -> phase 0->1 (cnt_clr=1 one cycle) ->2; votes_accepted=0.
REQ-032 In OPEN, booth_req=4'b1111 with choices 0,1,2,3, each booth drops req after ack -> acks in order booth0,1,2,3 on consecutive cycles, cnt_sel=0,1,2,3, votes_accepted=4.
REQ-033 Booth 2 holds req high for 5 cycles -> exactly one ack and one cnt_inc; a second ack only after req goes low then high again.
REQ-034 Booth 1 requests in the same cycle close_poll=1 is sampled -> no ack; phase 2->3->4; a grant registered one cycle earlier still produces its ack in CLOSING.
REQ-035 Run 300 single-booth ballots -> votes_accepted holds 255; a subsequent open_poll in CLOSED -> CLEAR and count 0.
REQ-036 Assert rst in the cycle after a grant -> no ack or cnt_inc follows; phase=0; the next grant after reopening goes to booth 0 first.
